modport_periph: RTL and testbench
=================================

# modport_periph

AXI4-Lite slave peripheral mapping a 4-bit LED register, a 4-digit multiplexed seven-segment display and an edge-triggered external interrupt into five 32-bit registers. It sits on the SoC AXI4-Lite interconnect as a leaf slave and drives board-level LEDs, 7-seg and one interrupt line to the CPU.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (WSTRB is DATA_WIDTH/8 = 4 bits)
- DIGIT_CYCLES, 1000, ACLK cycles each 7-seg digit is lit (≥2)

- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  reset; synchronous, active-high (name kept for codebase consistency)
- AWADDR/AWPROT/AWVALID  in  ADDR_WIDTH/3/1; AWREADY out 1: write address channel
- WDATA/WSTRB/WVALID  in  DATA_WIDTH/4/1; WREADY out 1: write data channel
- BRESP out 2, BVALID out 1, BREADY in 1: write response
- ARADDR/ARPROT/ARVALID  in  ADDR_WIDTH/3/1; ARREADY out 1: read address
- RDATA out DATA_WIDTH, RRESP out 2, RVALID out 1, RREADY in 1: read data
- ext_irq_in  in  1  asynchronous external interrupt request
- leds  out  4  LED register
- seg_cathode  out  7  active-low segments {g,f,e,d,c,b,a}
- seg_anode  out  4  active-low digit enables
- irq_out  out  1  interrupt to CPU, active-high

## Operation
- Decode on address bits [7:2]; bits [1:0] and above [7] ignored; AWPROT/ARPROT ignored.
- 0x00 LED: RW, bits[3:0] drive leds; other bits read 0.
- 0x04 SEG: RW, bits[15:0] = four hex digits, digit k = bits[4k+3:4k].
- 0x08 IRQ_EN: RW, bit0.
- 0x0C IRQ_STAT: bit0 set by rising edge of ext_irq_in; write 1 clears (W1C); write 0 no effect.
- 0x10 ID: read-only 0xA11E_0001; writes ignored, OKAY.
- Unmapped address: write ignored, BRESP=2'b10 (SLVERR); read RDATA=0, RRESP=2'b10. Mapped: OKAY 2'b00.
- WSTRB byte lanes gate writes per byte; strobe 0 leaves that byte unchanged.
- ext_irq_in passes 2-flop synchronizer then edge detector; set and W1C clear in same cycle: set wins.
- irq_out = registered (IRQ_EN & IRQ_STAT).
- 7-seg: counter cycles digits 0→1→2→3→0 every DIGIT_CYCLES; digit k lit by seg_anode[k]=0; cathode = hex decode of active nibble (0→7'b1000000, 1→7'b1111001, …, F→7'b0001110).

## Timing
- Reset values: AWREADY/WREADY/BVALID/ARREADY/RVALID=0, BRESP/RRESP=0, RDATA=0, all registers 0, leds=0, irq_out=0, seg_anode=4'b1110, seg_cathode=7'b1000000, digit counter 0.
- Write: when AWVALID&&WVALID, !BVALID and ready low, AWREADY and WREADY both rise next cycle for exactly one cycle; register updates on that handshake edge; BVALID rises next cycle and holds with BRESP stable until BREADY sampled high. Only AWVALID or only WVALID present: no ready asserted.
- Read: when ARVALID, !RVALID and ARREADY low, ARREADY pulses one cycle next cycle; RDATA/RRESP captured at handshake; RVALID next cycle, held with stable data until RREADY.
- Write and read channels independent; simultaneous write and read to same register: read returns pre-write value.
- leds update one cycle after write handshake; irq_out rises 4 cycles after ext_irq_in rise (2 sync, 1 status, 1 output) when enabled.
- Reset mid-transaction aborts: all VALID/READY low next edge, no response issued.

## Structure
- Shared package modport_pkg: register offsets, ID constant, RESP_OKAY/RESP_SLVERR, hex-to-7seg function.
- One sub-module seg7_mux (digit counter, anode rotation, decode); AXI slave and register file in top.

## Test plan
- Reset: assert ARESETn 2 cycles → all outputs at reset values, seg_anode=4'b1110, ID read returns 0xA11E_0001 OKAY.
- Write 0x00 data 0x0000_000A WSTRB 4'hF → BRESP 0, leds=4'hA; read back 0xA.
- Write 0x04 0x1234 WSTRB 4'b0001 after 0xFFFF → SEG=0xFF34; run 4·DIGIT_CYCLES → cathodes 4,3,F,F patterns in order.
- IRQ_EN=1, pulse ext_irq_in → irq_out=1 after 4 cycles; write 1 to 0x0C → irq_out 0; IRQ_EN=0 → irq_out stays 0.
- Read/write 0x40 → RRESP/BRESP=2'b10, RDATA=0, no register change.
- Hold BREADY/RREADY low 5 cycles → BVALID/RVALID and data stable; AWVALID without WVALID → no AWREADY.

Source files
------------

// File: rtl/modport_pkg.sv
// rtl/modport_pkg.sv - shared register map, response codes and helpers for modport_periph
package modport_pkg;

    localparam logic [5:0] REG_LED      = 6'h00;
    localparam logic [5:0] REG_SEG      = 6'h01;
    localparam logic [5:0] REG_IRQ_EN   = 6'h02;
    localparam logic [5:0] REG_IRQ_STAT = 6'h03;
    localparam logic [5:0] REG_ID       = 6'h04;

    localparam logic [31:0] ID_VALUE    = 32'hA11E_0001;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/modport_periph_seg7_mux.sv
// rtl/modport_periph_seg7_mux.sv - four-digit multiplexed seven-segment driver
module seg7_mux
    import modport_pkg::*;
#(
    parameter int DIGIT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    output logic [3:0]  seg_anode,
    output logic [6:0]  seg_cathode
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    nib;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sel_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sel_d = sel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
        end
    end

    always_comb begin
        nib       = digits[3:0];
        seg_anode = 4'b1110;
        case (sel_q)
            2'd0: begin nib = digits[3:0];   seg_anode = 4'b1110; end
            2'd1: begin nib = digits[7:4];   seg_anode = 4'b1101; end
            2'd2: begin nib = digits[11:8];  seg_anode = 4'b1011; end
            default: begin nib = digits[15:12]; seg_anode = 4'b0111; end
        endcase
        seg_cathode = hex7(nib);
    end

endmodule

// File: rtl/modport_periph.sv
// rtl/modport_periph.sv - AXI4-Lite slave with LED, seven-segment and edge interrupt registers
module modport_periph
    import modport_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DIGIT_CYCLES = 1000
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    input  logic                    ext_irq_in,
    output logic [3:0]              leds,
    output logic [6:0]              seg_cathode,
    output logic [3:0]              seg_anode,
    output logic                    irq_out
);

    // ARESETn is an active-high synchronous reset despite its name
    logic rst;
    assign rst = ARESETn;

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  led_q, led_d;
    logic [15:0] seg_q, seg_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_stat_q, irq_stat_d;
    logic        irq_out_q, irq_out_d;
    logic        sync1_q, sync2_q, sync3_q;

    logic [5:0]  wr_idx, rd_idx;
    logic        wr_mapped, rd_mapped;
    logic        wr_hs, rd_hs, irq_rise;
    logic [31:0] wr_cur, rd_val, wr_merged;

    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[ADDR_WIDTH-1:8], AWADDR[1:0],
                           ARADDR[ADDR_WIDTH-1:8], ARADDR[1:0]};

    assign wr_idx    = AWADDR[7:2];
    assign rd_idx    = ARADDR[7:2];
    assign wr_mapped = (wr_idx <= REG_ID);
    assign rd_mapped = (rd_idx <= REG_ID);
    assign wr_hs     = awready_q && AWVALID && WVALID;
    assign rd_hs     = arready_q && ARVALID;
    assign irq_rise  = sync2_q && !sync3_q;

    function automatic logic [31:0] reg_value(input logic [5:0] idx,
                                              input logic [3:0] led_v,
                                              input logic [15:0] seg_v,
                                              input logic en_v,
                                              input logic stat_v);
        logic [31:0] v;
        case (idx)
            REG_LED:      v = {28'd0, led_v};
            REG_SEG:      v = {16'd0, seg_v};
            REG_IRQ_EN:   v = {31'd0, en_v};
            REG_IRQ_STAT: v = {31'd0, stat_v};
            REG_ID:       v = ID_VALUE;
            default:      v = 32'd0;
        endcase
        return v;
    endfunction

    always_comb begin
        wr_cur    = reg_value(wr_idx, led_q, seg_q, irq_en_q, irq_stat_q);
        rd_val    = reg_value(rd_idx, led_q, seg_q, irq_en_q, irq_stat_q);
        wr_merged = apply_strb(wr_cur, WDATA[31:0], WSTRB[3:0]);
    end

    // Write channel and register file
    always_comb begin
        awready_d  = AWVALID && WVALID && !bvalid_q && !awready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        led_d      = led_q;
        seg_d      = seg_q;
        irq_en_d   = irq_en_q;
        irq_stat_d = irq_stat_q;
        if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_mapped ? RESP_OKAY : RESP_SLVERR;
            case (wr_idx)
                REG_LED:      led_d    = wr_merged[3:0];
                REG_SEG:      seg_d    = wr_merged[15:0];
                REG_IRQ_EN:   irq_en_d = wr_merged[0];
                REG_IRQ_STAT: if (WSTRB[0] && WDATA[0]) irq_stat_d = 1'b0;
                default: ;
            endcase
        end
        // A fresh edge outranks a simultaneous W1C clear
        if (irq_rise) begin
            irq_stat_d = 1'b1;
        end
        irq_out_d = irq_en_q && irq_stat_q;
    end

    // Read channel
    always_comb begin
        arready_d = ARVALID && !rvalid_q && !arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_mapped ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = rd_mapped ? rd_val : 32'd0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (rst) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= 32'd0;
            led_q      <= 4'd0;
            seg_q      <= 16'd0;
            irq_en_q   <= 1'b0;
            irq_stat_q <= 1'b0;
            irq_out_q  <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            irq_out_q  <= irq_out_d;
            sync1_q    <= ext_irq_in;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = awready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = DATA_WIDTH'(rdata_q);
    assign leds    = led_q;
    assign irq_out = irq_out_q;

    seg7_mux #(.DIGIT_CYCLES(DIGIT_CYCLES)) u_seg7_mux (
        .clk         (ACLK),
        .rst         (rst),
        .digits      (seg_q),
        .seg_anode   (seg_anode),
        .seg_cathode (seg_cathode)
    );

endmodule

// File: tb/tb_modport_periph.sv
// tb/tb_modport_periph.sv - scoreboard bench for modport_periph
module tb_modport_periph;

    localparam int DC = 8;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [31:0] AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [31:0] ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b1;
    logic        ext_irq_in = 1'b0;
    logic [3:0]  leds;
    logic [6:0]  seg_cathode;
    logic [3:0]  seg_anode;
    logic        irq_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];

    always #5 ACLK = ~ACLK;

    modport_periph #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DIGIT_CYCLES(DC)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .ext_irq_in(ext_irq_in), .leds(leds), .seg_cathode(seg_cathode),
        .seg_anode(seg_anode), .irq_out(irq_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is accepted
    initial begin
        forever begin
            @(negedge ACLK);
            if (BVALID && BREADY) begin
                if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", {62'd0, BRESP}, {62'd0, exp_b_q.pop_front()});
            end
            if (RVALID && RREADY) begin
                if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
                else check("rresp_rdata", {30'd0, RRESP, RDATA}, {30'd0, exp_r_q.pop_front()});
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input bit hold_b);
        bit got;
        logic [1:0] held;
        exp_b_q.push_back(exp_resp);
        if (hold_b) BREADY = 1'b0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            got = AWREADY && WREADY;
        end
        if (!got) check("aw_timeout", 0, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (i > 0) @(negedge ACLK);
            else @(negedge ACLK);
            got = BVALID;
        end
        if (!got) check("b_timeout", 0, 1);
        if (hold_b) begin
            held = BRESP;
            for (int i = 0; i < 5; i++) begin
                @(negedge ACLK);
                check("bvalid_hold", {63'd0, BVALID}, 1);
                check("bresp_hold", {62'd0, BRESP}, {62'd0, held});
            end
            @(posedge ACLK); #1;
            BREADY = 1'b1;
        end
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input bit hold_r);
        bit got;
        exp_r_q.push_back({exp_resp, exp_data});
        if (hold_r) RREADY = 1'b0;
        ARADDR = addr; ARVALID = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            got = ARREADY;
        end
        if (!got) check("ar_timeout", 0, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            got = RVALID;
        end
        if (!got) check("r_timeout", 0, 1);
        if (hold_r) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge ACLK);
                check("rvalid_hold", {63'd0, RVALID}, 1);
                check("rdata_hold", {32'd0, RDATA}, {32'd0, exp_data});
            end
            @(posedge ACLK); #1;
            RREADY = 1'b1;
        end
        @(posedge ACLK); #1;
    endtask

    initial begin
        bit seen;
        logic [3:0] prev_an;

        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b0;
        @(negedge ACLK);
        check("rst_ready", {60'd0, AWREADY, WREADY, ARREADY, 1'b0}, 0);
        check("rst_valid", {62'd0, BVALID, RVALID}, 0);
        check("rst_resp_data", {28'd0, BRESP, RRESP, RDATA}, 0);
        check("rst_leds", {60'd0, leds}, 0);
        check("rst_irq", {63'd0, irq_out}, 0);
        check("rst_anode", {60'd0, seg_anode}, 64'hE);
        check("rst_cathode", {57'd0, seg_cathode}, 64'b1000000);

        axi_read(32'h10, 32'hA11E_0001, 2'b00, 0);

        axi_write(32'h00, 32'h0000_000A, 4'hF, 2'b00, 0);
        check("leds_a", {60'd0, leds}, 64'hA);
        axi_read(32'h00, 32'h0000_000A, 2'b00, 0);

        axi_write(32'h04, 32'h0000_FFFF, 4'hF, 2'b00, 0);
        axi_write(32'h04, 32'h0000_1234, 4'b0001, 2'b00, 0);
        axi_read(32'h04, 32'h0000_FF34, 2'b00, 0);

        seen = 0;
        for (int i = 0; i < 8 * DC && !seen; i++) begin
            prev_an = seg_anode;
            @(negedge ACLK);
            seen = (prev_an != 4'b1110) && (seg_anode == 4'b1110);
        end
        check("seg_sync", {63'd0, seen}, 1);
        check("seg_d0", {53'd0, seg_anode, seg_cathode}, {53'd0, 4'b1110, 7'b0011001});
        repeat (DC) @(negedge ACLK);
        check("seg_d1", {53'd0, seg_anode, seg_cathode}, {53'd0, 4'b1101, 7'b0110000});
        repeat (DC) @(negedge ACLK);
        check("seg_d2", {53'd0, seg_anode, seg_cathode}, {53'd0, 4'b1011, 7'b0001110});
        repeat (DC) @(negedge ACLK);
        check("seg_d3", {53'd0, seg_anode, seg_cathode}, {53'd0, 4'b0111, 7'b0001110});
        repeat (DC) @(negedge ACLK);
        check("seg_wrap", {53'd0, seg_anode, seg_cathode}, {53'd0, 4'b1110, 7'b0011001});

        axi_write(32'h08, 32'h1, 4'hF, 2'b00, 0);
        @(posedge ACLK); #1 ext_irq_in = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("irq_early", {63'd0, irq_out}, 0);
        @(negedge ACLK);
        check("irq_4cyc", {63'd0, irq_out}, 1);
        #1 ext_irq_in = 1'b0;
        axi_read(32'h0C, 32'h1, 2'b00, 0);
        axi_write(32'h0C, 32'h0, 4'hF, 2'b00, 0);
        axi_read(32'h0C, 32'h1, 2'b00, 0);
        axi_write(32'h0C, 32'h1, 4'hF, 2'b00, 0);
        @(negedge ACLK);
        check("irq_cleared", {63'd0, irq_out}, 0);
        axi_read(32'h0C, 32'h0, 2'b00, 0);

        axi_write(32'h08, 32'h0, 4'hF, 2'b00, 0);
        @(posedge ACLK); #1 ext_irq_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (irq_out) seen = 1;
        end
        check("irq_disabled", {63'd0, seen}, 0);
        #1 ext_irq_in = 1'b0;
        axi_read(32'h0C, 32'h1, 2'b00, 0);

        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        axi_read(32'h40, 32'h0, 2'b10, 0);
        axi_read(32'h00, 32'h0000_000A, 2'b00, 0);
        axi_write(32'h10, 32'h0, 4'hF, 2'b00, 0);
        axi_read(32'h10, 32'hA11E_0001, 2'b00, 0);

        axi_write(32'h00, 32'h5, 4'hF, 2'b00, 1);
        axi_read(32'h04, 32'h0000_FF34, 2'b00, 1);

        fork
            axi_write(32'h00, 32'h3, 4'hF, 2'b00, 0);
            axi_read(32'h00, 32'h5, 2'b00, 0);
        join
        check("leds_3", {60'd0, leds}, 64'h3);
        axi_read(32'h00, 32'h3, 2'b00, 0);

        AWADDR = 32'h00; AWVALID = 1'b1; WVALID = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            if (AWREADY || WREADY) seen = 1;
        end
        check("aw_only_no_ready", {63'd0, seen}, 0);
        #1 AWVALID = 1'b0;
        repeat (2) @(negedge ACLK);

        check("b_queue_empty", 64'(exp_b_q.size()), 0);
        check("r_queue_empty", 64'(exp_r_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
